toy_bus_slv_endpoint: RTL and testbench
=======================================

// Module: toy_bus_slv_endpoint
// PURPOSE
//  Target-side bus endpoint; sits directly downstream of the sysbus, fed by initiator nodes (e.g. the debug node).
//  Accepts routed bus requests (addr/data/strb/opcode/src_id/tgt_id), forwards them to a plain slave port,
//  records src_id/opcode per outstanding request, and returns slave acks as bus ack packets addressed back to the requester.
//  Slave is in-order; up to OST_DEPTH requests may be in flight.
// PARAMETERS
//  NODE_ID    4'd5  this endpoint's bus id; driven on in0_ack_src_id
//  OST_DEPTH  4     max outstanding requests (power of 2, >=2)
//  ADDR_W     32    address width
//  DATA_W     32    data width; strb width = DATA_W/8
//  ID_W       4     bus node id width
// PORTS
//  clk              in   1         clock
//  rst              in   1         synchronous reset, active-high
//  in0_req_vld      in   1         bus request valid
//  in0_req_rdy      out  1         bus request ready
//  in0_req_addr     in   ADDR_W    request address
//  in0_req_data     in   DATA_W    write data
//  in0_req_strb     in   DATA_W/8  byte strobes
//  in0_req_opcode   in   1         0=read 1=write
//  in0_req_src_id   in   ID_W      requester id
//  in0_req_tgt_id   in   ID_W      target id (informational; routing done upstream)
//  in0_ack_vld      out  1         bus ack valid
//  in0_ack_rdy      in   1         bus ack ready
//  in0_ack_opcode   out  1         opcode of the acked request
//  in0_ack_data     out  DATA_W    read data (slave value for writes too)
//  in0_ack_src_id   out  ID_W      constant NODE_ID
//  in0_ack_tgt_id   out  ID_W      stored src_id of the acked request
//  out0_req_vld/rdy out/in 1       slave request handshake
//  out0_req_addr/data/strb/opcode out  as in0  slave request payload (pass-through)
//  out0_ack_vld/rdy in/out 1       slave ack handshake
//  out0_ack_data    in   DATA_W    slave response data
//  ost_cnt          out  $clog2(OST_DEPTH+1)  outstanding count
//  idle             out  1         ost_cnt==0 and no ack held
// BEHAVIOUR
//  - Reset: ost_cnt=0, FIFO rd/wr ptr=0, idle=1, in0_ack_vld=0, skid entries invalid; all vld outputs 0.
//  - Request path combinational, 0 latency: out0_req_vld=in0_req_vld&!full; in0_req_rdy=out0_req_rdy&!full.
//  - Push {src_id,opcode} into id FIFO on out0_req_vld&out0_req_rdy; ost_cnt++.
//  - full=(ost_cnt==OST_DEPTH); rdy uses registered full only -- no same-cycle pop bypass.
//  - Ack path: out0_ack_rdy gated by !empty; ack with empty FIFO stalls (never dropped, never emitted).
//  - Pop on in0_ack handshake; ost_cnt--. Push+pop same cycle: ost_cnt unchanged, both ptrs advance.
//  - Pointers wrap modulo OST_DEPTH; count is separate, so full/empty are unambiguous.
//  - Payload held stable while in0_ack_vld&!in0_ack_rdy.
//  - Reset mid-operation: in-flight requests forgotten; outputs to reset values next cycle.
// CONFIGURATION
//  TOY_BUS_EP_ACK_SKID_EN defined: 2-entry skid buffer between slave ack and bus ack;
//    1-cycle ack latency; out0_ack_rdy=!skid_full&!empty; no comb path in0_ack_rdy->out0_ack_rdy;
//    FIFO pop on skid load; ost_cnt decrements on bus handshake (entry held until then).
//  Undefined: in0_ack_vld=out0_ack_vld&!empty, out0_ack_rdy=in0_ack_rdy&!empty, 0 latency, pop on handshake.
// STRUCTURE
//  toy_bus_pkg: ID_W, node id constants (NODE_ID values), opcode localparams OP_RD=0/OP_WR=1, ack/req field widths.
//  Sub-module toy_bus_id_fifo: sync FIFO of {ID_W+1} bits, depth OST_DEPTH, push/pop/full/empty/count.
// TESTING
//  1. Single read src_id=6 addr=0x5000_0000, slave ack data=0xDEAD_BEEF -> ack tgt_id=6 src_id=5 opcode=0 data=0xDEAD_BEEF; idle back to 1.
//  2. 4 back-to-back writes src 6,1,2,6, slave ack withheld -> 5th req sees in0_req_rdy=0, ost_cnt=4; acks return tgt 6,1,2,6 in order.
//  3. Full with ack handshake in same cycle -> rdy stays 0 that cycle, rises next; ost_cnt 4->3.
//  4. in0_ack_rdy=0 for 5 cycles -> ack vld/payload stable, out0_ack_rdy=0 (no-skid) or skid fills then stalls.
//  5. out0_ack_vld with empty FIFO -> out0_ack_rdy=0, in0_ack_vld=0.
//  6. rst asserted with 3 outstanding -> next cycle ost_cnt=0, idle=1, in0_ack_vld=0.

Source files
------------

// File: rtl/toy_bus_slv_endpoint_pkg.sv
// rtl/toy_bus_slv_endpoint_pkg.sv - shared bus constants: id width, node ids, opcodes
package toy_bus_slv_endpoint_pkg;

    localparam int BUS_ID_W = 4;

    localparam logic [BUS_ID_W-1:0] NODE_EP  = 4'd5;
    localparam logic [BUS_ID_W-1:0] NODE_DBG = 4'd6;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/toy_bus_slv_endpoint_if.sv
// rtl/toy_bus_slv_endpoint_if.sv - bus-side and slave-side handshake bundle of the endpoint
interface toy_bus_slv_endpoint_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic                in0_req_vld;
    logic                in0_req_rdy;
    logic [ADDR_W-1:0]   in0_req_addr;
    logic [DATA_W-1:0]   in0_req_data;
    logic [DATA_W/8-1:0] in0_req_strb;
    logic                in0_req_opcode;
    logic [ID_W-1:0]     in0_req_src_id;
    logic [ID_W-1:0]     in0_req_tgt_id;

    logic                in0_ack_vld;
    logic                in0_ack_rdy;
    logic                in0_ack_opcode;
    logic [DATA_W-1:0]   in0_ack_data;
    logic [ID_W-1:0]     in0_ack_src_id;
    logic [ID_W-1:0]     in0_ack_tgt_id;

    logic                out0_req_vld;
    logic                out0_req_rdy;
    logic [ADDR_W-1:0]   out0_req_addr;
    logic [DATA_W-1:0]   out0_req_data;
    logic [DATA_W/8-1:0] out0_req_strb;
    logic                out0_req_opcode;

    logic                out0_ack_vld;
    logic                out0_ack_rdy;
    logic [DATA_W-1:0]   out0_ack_data;

    modport slave (
        input  in0_req_vld, in0_req_addr, in0_req_data, in0_req_strb,
               in0_req_opcode, in0_req_src_id, in0_req_tgt_id, in0_ack_rdy,
               out0_req_rdy, out0_ack_vld, out0_ack_data,
        output in0_req_rdy, in0_ack_vld, in0_ack_opcode, in0_ack_data,
               in0_ack_src_id, in0_ack_tgt_id,
               out0_req_vld, out0_req_addr, out0_req_data, out0_req_strb,
               out0_req_opcode, out0_ack_rdy
    );

    modport master (
        output in0_req_vld, in0_req_addr, in0_req_data, in0_req_strb,
               in0_req_opcode, in0_req_src_id, in0_req_tgt_id, in0_ack_rdy,
               out0_req_rdy, out0_ack_vld, out0_ack_data,
        input  in0_req_rdy, in0_ack_vld, in0_ack_opcode, in0_ack_data,
               in0_ack_src_id, in0_ack_tgt_id,
               out0_req_vld, out0_req_addr, out0_req_data, out0_req_strb,
               out0_req_opcode, out0_ack_rdy
    );

endinterface

// File: rtl/toy_bus_slv_endpoint_id_fifo.sv
// rtl/toy_bus_slv_endpoint_id_fifo.sv - sync FIFO of {src_id,opcode} tags for outstanding requests
module toy_bus_id_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/toy_bus_slv_endpoint.sv
// rtl/toy_bus_slv_endpoint.sv - bus target endpoint with id tracking; TOY_BUS_EP_ACK_SKID_EN adds a 2-entry ack skid
module toy_bus_slv_endpoint
    import toy_bus_slv_endpoint_pkg::*;
#(
    parameter int                  ID_W      = BUS_ID_W,
    parameter logic [ID_W-1:0]     NODE_ID   = NODE_EP,
    parameter int                  OST_DEPTH = 4,
    parameter int                  ADDR_W    = 32,
    parameter int                  DATA_W    = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    toy_bus_slv_endpoint_if.slave           bus,
    output logic [$clog2(OST_DEPTH+1)-1:0]  ost_cnt,
    output logic                            idle
);
    localparam int CNT_W = $clog2(OST_DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OST_DEPTH);

    logic              full;
    logic              req_fire;
    logic              ack_fire;
    logic              ack_vld;
    logic              out0_ack_rdy_w;
    logic [ID_W:0]     ack_id;
    logic [DATA_W-1:0] ack_data;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ID_W:0]     fifo_rd_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              unused_sig;

    // Ready looks only at the registered count; a same-cycle pop never frees a slot early.
    assign full                = (ost_cnt == FULL_CNT);
    assign bus.out0_req_vld    = bus.in0_req_vld & ~full;
    assign bus.in0_req_rdy     = bus.out0_req_rdy & ~full;
    assign bus.out0_req_addr   = bus.in0_req_addr;
    assign bus.out0_req_data   = bus.in0_req_data;
    assign bus.out0_req_strb   = bus.in0_req_strb;
    assign bus.out0_req_opcode = bus.in0_req_opcode;

    assign req_fire = bus.out0_req_vld & bus.out0_req_rdy;
    assign ack_fire = ack_vld & bus.in0_ack_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            ost_cnt <= '0;
        end else begin
            case ({req_fire, ack_fire})
                2'b10:   ost_cnt <= ost_cnt + CNT_W'(1);
                2'b01:   ost_cnt <= ost_cnt - CNT_W'(1);
                default: ost_cnt <= ost_cnt;
            endcase
        end
    end

    toy_bus_id_fifo #(
        .WIDTH (ID_W + 1),
        .DEPTH (OST_DEPTH)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data ({bus.in0_req_src_id, bus.in0_req_opcode}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef TOY_BUS_EP_ACK_SKID_EN
    logic [1:0]        sk_cnt;
    logic              sk_rd;
    logic              sk_wr;
    logic              sk_load;
    logic              skid_full;
    logic [DATA_W-1:0] sk_data [0:1];
    logic [ID_W:0]     sk_id   [0:1];

    // Tag leaves the FIFO when the slave ack is captured; ost_cnt keeps counting it until the bus takes it.
    assign skid_full      = (sk_cnt == 2'd2);
    assign out0_ack_rdy_w = ~skid_full & ~fifo_empty;
    assign sk_load        = bus.out0_ack_vld & out0_ack_rdy_w;
    assign fifo_pop       = sk_load;
    assign ack_vld        = (sk_cnt != 2'd0);
    assign ack_id         = sk_id[sk_rd];
    assign ack_data       = sk_data[sk_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            sk_cnt <= 2'd0;
            sk_rd  <= 1'b0;
            sk_wr  <= 1'b0;
        end else begin
            if (sk_load) begin
                sk_data[sk_wr] <= bus.out0_ack_data;
                sk_id[sk_wr]   <= fifo_rd_data;
                sk_wr          <= ~sk_wr;
            end
            if (ack_fire) begin
                sk_rd <= ~sk_rd;
            end
            case ({sk_load, ack_fire})
                2'b10:   sk_cnt <= sk_cnt + 2'd1;
                2'b01:   sk_cnt <= sk_cnt - 2'd1;
                default: sk_cnt <= sk_cnt;
            endcase
        end
    end
`else
    // An ack arriving with no tag outstanding is stalled, never forwarded.
    assign ack_vld        = bus.out0_ack_vld & ~fifo_empty;
    assign out0_ack_rdy_w = bus.in0_ack_rdy & ~fifo_empty;
    assign fifo_pop       = ack_fire;
    assign ack_id         = fifo_rd_data;
    assign ack_data       = bus.out0_ack_data;
`endif

    assign bus.out0_ack_rdy   = out0_ack_rdy_w;
    assign bus.in0_ack_vld    = ack_vld;
    assign bus.in0_ack_opcode = ack_id[0];
    assign bus.in0_ack_tgt_id = ack_id[ID_W:1];
    assign bus.in0_ack_data   = ack_data;
    assign bus.in0_ack_src_id = NODE_ID;

    assign idle = (ost_cnt == '0) & ~ack_vld;

    assign unused_sig = ^{fifo_full, fifo_count, bus.in0_req_tgt_id};

endmodule

// File: tb/tb_toy_bus_slv_endpoint.sv
// tb/tb_toy_bus_slv_endpoint.sv - vector-table and sequence bench for toy_bus_slv_endpoint
module tb_toy_bus_slv_endpoint;
    import toy_bus_slv_endpoint_pkg::*;

    logic       clk;
    logic       rst;
    logic [2:0] ost_cnt;
    logic       idle;
    int         checks;
    int         errors;

    toy_bus_slv_endpoint_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

    toy_bus_slv_endpoint #(
        .ID_W      (4),
        .NODE_ID   (4'd5),
        .OST_DEPTH (4),
        .ADDR_W    (32),
        .DATA_W    (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ost_cnt (ost_cnt),
        .idle    (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic        orr;
        logic [3:0]  src;
        logic        op;
        logic [31:0] addr;
        logic        oav;
        logic [31:0] adata;
        logic        iar;
        logic        e_rdy;
        logic        e_ovld;
        logic        e_avld;
        logic        e_oardy;
        logic        pay;
        logic [3:0]  e_tgt;
        logic        e_op;
        logic [2:0]  e_cnt;
        logic        e_idle;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rv, orr, input logic [3:0] src, input logic op,
                                input logic [31:0] addr, input logic oav, input logic [31:0] adata,
                                input logic iar, e_rdy, e_ovld, e_avld, e_oardy, pay,
                                input logic [3:0] e_tgt, input logic e_op, input logic [2:0] e_cnt,
                                input logic e_idle);
        vec_t v;
        v.rv = rv; v.orr = orr; v.src = src; v.op = op; v.addr = addr;
        v.oav = oav; v.adata = adata; v.iar = iar;
        v.e_rdy = e_rdy; v.e_ovld = e_ovld; v.e_avld = e_avld; v.e_oardy = e_oardy;
        v.pay = pay; v.e_tgt = e_tgt; v.e_op = e_op; v.e_cnt = e_cnt; v.e_idle = e_idle;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rv, orr, input logic [3:0] src, input logic op,
                         input logic [31:0] addr, input logic oav, input logic [31:0] adata,
                         input logic iar);
        bus.in0_req_vld    = rv;
        bus.out0_req_rdy   = orr;
        bus.in0_req_src_id = src;
        bus.in0_req_tgt_id = 4'd5;
        bus.in0_req_opcode = op;
        bus.in0_req_addr   = addr;
        bus.in0_req_data   = addr ^ 32'hA5A5_0000;
        bus.in0_req_strb   = 4'hF;
        bus.out0_ack_vld   = oav;
        bus.out0_ack_data  = adata;
        bus.in0_ack_rdy    = iar;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // rv orr src op addr oav adata iar | rdy ovld avld oardy pay tgt op cnt idle
        vecs.push_back(mk(1,1,4'd6,OP_RD,32'h5000_0000,0,32'h0,1,            1,1,0,0,0,4'd0,0,3'd1,1));
        vecs.push_back(mk(0,1,4'd0,OP_RD,32'h0,1,32'hDEAD_BEEF,1,           1,0,1,1,1,4'd6,OP_RD,3'd0,0));
        vecs.push_back(mk(0,1,4'd0,OP_RD,32'h0,0,32'h0,1,                   1,0,0,0,0,4'd0,0,3'd0,1));
        vecs.push_back(mk(0,1,4'd0,OP_RD,32'h0,1,32'h1234,1,                1,0,0,0,0,4'd0,0,3'd0,1));
        vecs.push_back(mk(1,0,4'd7,OP_RD,32'h100,0,32'h0,1,                 0,1,0,0,0,4'd0,0,3'd0,1));
        vecs.push_back(mk(1,1,4'd6,OP_WR,32'h10,0,32'h0,0,                  1,1,0,0,0,4'd0,0,3'd1,1));
        vecs.push_back(mk(1,1,4'd1,OP_WR,32'h14,0,32'h0,0,                  1,1,0,0,0,4'd0,0,3'd2,0));
        vecs.push_back(mk(1,1,4'd2,OP_WR,32'h18,0,32'h0,0,                  1,1,0,0,0,4'd0,0,3'd3,0));
        vecs.push_back(mk(1,1,4'd6,OP_WR,32'h1C,0,32'h0,0,                  1,1,0,0,0,4'd0,0,3'd4,0));
        vecs.push_back(mk(1,1,4'd3,OP_WR,32'h40,0,32'h0,0,                  0,0,0,0,0,4'd0,0,3'd4,0));
        vecs.push_back(mk(1,1,4'd3,OP_WR,32'h40,1,32'h11,1,                 0,0,1,1,1,4'd6,OP_WR,3'd3,0));
        vecs.push_back(mk(1,1,4'd3,OP_RD,32'h44,0,32'h0,1,                  1,1,0,1,0,4'd0,0,3'd4,0));
        vecs.push_back(mk(0,1,4'd0,OP_RD,32'h0,1,32'h22,1,                  0,0,1,1,1,4'd1,OP_WR,3'd3,0));
        vecs.push_back(mk(0,1,4'd0,OP_RD,32'h0,1,32'h33,1,                  1,0,1,1,1,4'd2,OP_WR,3'd2,0));
        vecs.push_back(mk(0,1,4'd0,OP_RD,32'h0,1,32'h44,1,                  1,0,1,1,1,4'd6,OP_WR,3'd1,0));
        vecs.push_back(mk(0,1,4'd0,OP_RD,32'h0,1,32'h55,1,                  1,0,1,1,1,4'd3,OP_RD,3'd0,0));
        vecs.push_back(mk(0,1,4'd0,OP_RD,32'h0,0,32'h0,1,                   1,0,0,0,0,4'd0,0,3'd0,1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ost_cnt", ost_cnt, 3'd0);
        chk("reset_idle", idle, 1'b1);
        chk("reset_ack_vld", bus.in0_ack_vld, 1'b0);
        chk("reset_out0_req_vld", bus.out0_req_vld, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rv, vecs[i].orr, vecs[i].src, vecs[i].op, vecs[i].addr,
                  vecs[i].oav, vecs[i].adata, vecs[i].iar);
            #1;
            chk($sformatf("v%0d_in0_req_rdy", i), bus.in0_req_rdy, vecs[i].e_rdy);
            chk($sformatf("v%0d_out0_req_vld", i), bus.out0_req_vld, vecs[i].e_ovld);
            chk($sformatf("v%0d_in0_ack_vld", i), bus.in0_ack_vld, vecs[i].e_avld);
            chk($sformatf("v%0d_out0_ack_rdy", i), bus.out0_ack_rdy, vecs[i].e_oardy);
            chk($sformatf("v%0d_idle", i), idle, vecs[i].e_idle);
            if (vecs[i].e_ovld) begin
                chk($sformatf("v%0d_out0_req_addr", i), bus.out0_req_addr, vecs[i].addr);
                chk($sformatf("v%0d_out0_req_opcode", i), bus.out0_req_opcode, vecs[i].op);
            end
            if (vecs[i].pay) begin
                chk($sformatf("v%0d_ack_tgt_id", i), bus.in0_ack_tgt_id, vecs[i].e_tgt);
                chk($sformatf("v%0d_ack_src_id", i), bus.in0_ack_src_id, 4'd5);
                chk($sformatf("v%0d_ack_opcode", i), bus.in0_ack_opcode, vecs[i].e_op);
                chk($sformatf("v%0d_ack_data", i), bus.in0_ack_data, vecs[i].adata);
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ost_cnt", i), ost_cnt, vecs[i].e_cnt);
        end

        // Bus back-pressure on the ack path for five cycles.
        @(negedge clk);
        drive(1, 1, 4'd2, OP_RD, 32'h200, 0, 32'h0, 0);
        @(negedge clk);
        drive(0, 1, 4'd0, OP_RD, 32'h0, 1, 32'hCAFE_F00D, 0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall%0d_ack_vld", k), bus.in0_ack_vld, 1'b1);
            chk($sformatf("stall%0d_ack_tgt", k), bus.in0_ack_tgt_id, 4'd2);
            chk($sformatf("stall%0d_ack_data", k), bus.in0_ack_data, 32'hCAFE_F00D);
            chk($sformatf("stall%0d_out0_ack_rdy", k), bus.out0_ack_rdy, 1'b0);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_ost_cnt", k), ost_cnt, 3'd1);
            @(negedge clk);
        end
        bus.in0_ack_rdy = 1'b1;
        #1;
        chk("stall_release_out0_ack_rdy", bus.out0_ack_rdy, 1'b1);
        @(posedge clk);
        #1;
        chk("stall_release_ost_cnt", ost_cnt, 3'd0);

        // Reset with three requests in flight.
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            drive(1, 1, 4'(k), OP_WR, 32'h300 + 32'(k), 0, 32'h0, 0);
        end
        @(posedge clk);
        #1;
        chk("pre_rst_ost_cnt", ost_cnt, 3'd3);
        @(negedge clk);
        drive(0, 1, 4'd0, OP_RD, 32'h0, 1, 32'h77, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ost_cnt", ost_cnt, 3'd0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_ack_vld", bus.in0_ack_vld, 1'b0);
        chk("rst_out0_ack_rdy", bus.out0_ack_rdy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 4'd4, OP_RD, 32'h400, 0, 32'h0, 1);
        @(negedge clk);
        drive(0, 1, 4'd0, OP_RD, 32'h0, 1, 32'h8888_0000, 1);
        #1;
        chk("post_rst_ack_vld", bus.in0_ack_vld, 1'b1);
        chk("post_rst_ack_tgt", bus.in0_ack_tgt_id, 4'd4);
        @(posedge clk);
        #1;
        chk("post_rst_ost_cnt", ost_cnt, 3'd0);
        @(negedge clk);
        drive(0, 1, 4'd0, OP_RD, 32'h0, 0, 32'h0, 1);
        #1;
        chk("post_rst_idle", idle, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
